// File: rtl/div_bcd_formatter.sv
// -----------------------------------------------------------------------------
// div_bcd_formatter
//   Result stage behind the 8/4 restoring divider. It captures one
//   quotient/remainder pair and converts both values to packed BCD with a
//   serial shift-add-3 (double dabble) engine that handles one bit per clock.
//   It then holds the digits for a display/UART consumer under valid/ready.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE. out_valid is high only in DONE,
//   and the result stays stable until out_ready is seen. Inputs presented
//   outside IDLE are ignored.
//
//   FSM state is visible on the ports: IDLE = in_ready, SHIFT = busy,
//   DONE = out_valid.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   quoteint   in   divider quotient (QUOT_W bits)
//   remainder  in   divider remainder (REM_W bits)
//   in_valid   in   quoteint/remainder valid this cycle
//   in_ready   out  block idle; captures when in_valid is high
//   quot_bcd   out  {tens,ones} BCD of the quotient
//   rem_bcd    out  {hundreds,tens,ones} BCD of the remainder
//   out_valid  out  BCD outputs valid; held until out_ready
//   out_ready  in   consumer accepts the result
//   busy       out  conversion in progress (SHIFT)
//
// Optional feature (macro BCD_BLANK_EN)
//   This adds quot_blank[1:0] and rem_blank[2:0] (bit i = digit i). They are
//   registered together with the BCD digits. A bit is set when that digit and
//   all higher digits are zero. Digit 0 is never blanked.
// -----------------------------------------------------------------------------
module div_bcd_formatter #(
   parameter int REM_W  = 8,
   parameter int QUOT_W = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [QUOT_W-1:0] quoteint,
   input  logic [REM_W-1:0]  remainder,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        quot_bcd,
   output logic [11:0]       rem_bcd,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef BCD_BLANK_EN
   output logic [1:0]        quot_blank,
   output logic [2:0]        rem_blank,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REM_W-1:0]   rsrc_q, rsrc_d;
   logic [REM_W-1:0]   qsrc_q, qsrc_d;
   logic [11:0]        racc_q, racc_d;
   logic [7:0]         qacc_q, qacc_d;
   logic [7:0]         quot_bcd_q, quot_bcd_d;
   logic [11:0]        rem_bcd_q, rem_bcd_d;
`ifdef BCD_BLANK_EN
   logic [1:0]         quot_blank_q, quot_blank_d;
   logic [2:0]         rem_blank_q, rem_blank_d;
`endif

   // Correct one BCD nibble before the shift so that it carries properly.
   // The input is at most 9, so the result is at most 12. It fits in 4 bits.
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   logic [11:0] racc_corr;
   logic [7:0]  qacc_corr;

   assign racc_corr = {add3(racc_q[11:8]), add3(racc_q[7:4]), add3(racc_q[3:0])};
   assign qacc_corr = {add3(qacc_q[7:4]), add3(qacc_q[3:0])};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rsrc_d     = rsrc_q;
      qsrc_d     = qsrc_q;
      racc_d     = racc_q;
      qacc_d     = qacc_q;
      quot_bcd_d = quot_bcd_q;
      rem_bcd_d  = rem_bcd_q;
`ifdef BCD_BLANK_EN
      quot_blank_d = quot_blank_q;
      rem_blank_d  = rem_blank_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rsrc_d  = remainder;
               // The quotient is zero-extended so that both engines run in lockstep.
               qsrc_d  = {{(REM_W-QUOT_W){1'b0}}, quoteint};
               racc_d  = '0;
               qacc_d  = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // There are REM_W shift cycles (cnt 0..REM_W-1). The extra cycle
            // at cnt == REM_W publishes the accumulators. This gives the
            // 9-cycle accept-to-valid latency.
            if (cnt_q == CNT_W'(REM_W)) begin
               quot_bcd_d = qacc_q;
               rem_bcd_d  = racc_q;
`ifdef BCD_BLANK_EN
               quot_blank_d = {qacc_q[7:4] == 4'd0, 1'b0};
               rem_blank_d  = {racc_q[11:8] == 4'd0, racc_q[11:4] == 8'd0, 1'b0};
`endif
               state_d = DONE;
            end else begin
               racc_d = {racc_corr[10:0], rsrc_q[REM_W-1]};
               qacc_d = {qacc_corr[6:0], qsrc_q[REM_W-1]};
               rsrc_d = rsrc_q << 1;
               qsrc_d = qsrc_q << 1;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rsrc_q     <= '0;
         qsrc_q     <= '0;
         racc_q     <= '0;
         qacc_q     <= '0;
         quot_bcd_q <= '0;
         rem_bcd_q  <= '0;
`ifdef BCD_BLANK_EN
         quot_blank_q <= '0;
         rem_blank_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsrc_q     <= rsrc_d;
         qsrc_q     <= qsrc_d;
         racc_q     <= racc_d;
         qacc_q     <= qacc_d;
         quot_bcd_q <= quot_bcd_d;
         rem_bcd_q  <= rem_bcd_d;
`ifdef BCD_BLANK_EN
         quot_blank_q <= quot_blank_d;
         rem_blank_q  <= rem_blank_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT);
   assign out_valid = (state_q == DONE);
   assign quot_bcd  = quot_bcd_q;
   assign rem_bcd   = rem_bcd_q;
`ifdef BCD_BLANK_EN
   assign quot_blank = quot_blank_q;
   assign rem_blank  = rem_blank_q;
`endif

endmodule

// File: tb/tb_div_bcd_formatter.sv
// -----------------------------------------------------------------------------
// tb_div_bcd_formatter
//   Directed and random stimulus for div_bcd_formatter. Expected BCD values
//   come from a decimal-arithmetic model. They are queued when a pair is
//   driven and popped when the DUT hands a result over (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_div_bcd_formatter;

   localparam int W = 20;  // {quot_bcd[7:0], rem_bcd[11:0]}

   logic        clk;
   logic        reset;
   logic [3:0]  quoteint;
   logic [7:0]  remainder;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  quot_bcd;
   logic [11:0] rem_bcd;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
`ifdef BCD_BLANK_EN
   logic [1:0]  quot_blank;
   logic [2:0]  rem_blank;
`endif

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   div_bcd_formatter dut (
      .clk       (clk),
      .reset     (reset),
      .quoteint  (quoteint),
      .remainder (remainder),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quot_bcd  (quot_bcd),
      .rem_bcd   (rem_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef BCD_BLANK_EN
      .quot_blank(quot_blank),
      .rem_blank (rem_blank),
`endif
      .busy      (busy)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- model and checker ----------------
   function automatic logic [W-1:0] model(input int q, input int r);
      logic [7:0]  qb;
      logic [11:0] rb;
      qb = {4'(q / 10), 4'(q % 10)};
      rb = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
      return {qb, rb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("sb_quot_bcd", 32'(quot_bcd), 32'(e[19:12]));
            check("sb_rem_bcd", 32'(rem_bcd), 32'(e[11:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // On return, the time is 1 ns after the accept edge.
   task automatic drive(input int q, input int r);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      quoteint  = 4'(q);
      remainder = 8'(r);
      in_valid  = 1'b1;
      exp_q.push_back(model(q, r));
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("out_valid_wait", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      quoteint  = '0;
      remainder = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_quot_bcd", 32'(quot_bcd), 32'h0);
      check("rst_rem_bcd", 32'(rem_bcd), 32'h0);
`ifdef BCD_BLANK_EN
      check("rst_quot_blank", 32'(quot_blank), 32'd0);
      check("rst_rem_blank", 32'(rem_blank), 32'd0);
`endif
      @(posedge clk); #1;

      // 14 / 2 with latency: accept edge T, out_valid first seen at T+9
      drive(14, 2);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd0);
      repeat (8) @(posedge clk);
      #1 check("t1_valid_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("t1_valid_on", 32'(out_valid), 32'd1);
      check("t1_quot_bcd", 32'(quot_bcd), 32'h14);
      check("t1_rem_bcd", 32'(rem_bcd), 32'h002);
      drain();

      // extremes
      drive(15, 255);
      drain();
      drive(0, 0);
      drain();

      // backpressure: hold out_ready low for 5 cycles in DONE and pulse in_valid
      out_ready = 1'b0;
      drive(9, 123);
      wait_out_valid();
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            quoteint  = 4'd3;
            remainder = 8'd45;
            in_valid  = 1'b1;
         end else begin
            in_valid  = 1'b0;
         end
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_quot_bcd", 32'(quot_bcd), 32'h09);
         check("bp_rem_bcd", 32'(rem_bcd), 32'h123);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_rel_in_ready", 32'(in_ready), 32'd1);
      check("bp_rel_out_valid", 32'(out_valid), 32'd0);
      check("bp_hold_quot", 32'(quot_bcd), 32'h09);
      check("bp_hold_rem", 32'(rem_bcd), 32'h123);
      repeat (12) @(posedge clk);
      #1 check("bp_pulse_ignored", 32'(busy), 32'd0);
      check("bp_queue", 32'(exp_q.size()), 32'd0);

      // reset during the 4th SHIFT cycle aborts the conversion
      drive(5, 200);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      void'(exp_q.pop_back());
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_quot_bcd", 32'(quot_bcd), 32'h0);
      check("abort_rem_bcd", 32'(rem_bcd), 32'h0);
      drive(7, 9);
      drain();

      // back-to-back random pairs with in_valid held high
      for (int i = 0; i < 256; i++) begin
         int q, r, n;
         q = $urandom_range(15, 0);
         r = $urandom_range(255, 0);
         quoteint  = 4'(q);
         remainder = 8'(r);
         in_valid  = 1'b1;
         exp_q.push_back(model(q, r));
         @(posedge clk); #1;
         n = 0;
         while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check("rnd_ready_gap", 32'(n), 32'd10);
      end
      in_valid = 1'b0;
      drain();

`ifdef BCD_BLANK_EN
      drive(0, 7);
      wait_out_valid();
      check("blank_quot_0", 32'(quot_blank), 32'b10);
      check("blank_rem_7", 32'(rem_blank), 32'b110);
      drain();
      drive(0, 100);
      wait_out_valid();
      check("blank_quot_0b", 32'(quot_blank), 32'b10);
      check("blank_rem_100", 32'(rem_blank), 32'b000);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
